// File: rtl/dot_product_operand_fetch.sv
// ---------------------------------------------------------------------------
// dot_product_operand_fetch
//
// AXI4-Lite read-master front end of the dot-product accelerator. A job
// (base_a, base_b, length) is latched on an accepted start pulse. For each
// element i the block reads A[i], then B[i], with only one read outstanding
// at any time. Each completed (A[i], B[i]) pair is handed to the MAC stage
// through a 1-deep valid/ready output register.
//
// Element addresses are base + i*STRIDE_BYTES, computed modulo 2^ADDR_W.
// A non-OKAY read response aborts the job: no partial pair is emitted, the
// sticky error flag is set, and done pulses as for a normal job end.
//
// Ports
//   i_m_axi_aclk      clock
//   i_m_axi_areset    asynchronous reset, active-high
//   i_start           1-cycle job start, ignored while o_busy=1
//   i_base_a/_b       byte address of A[0]/B[0], sampled on accepted start
//   i_length          element count, sampled on accepted start
//   o_busy            job in progress
//   o_done            1-cycle pulse at job end (normal or aborted)
//   o_err             sticky read-error flag, cleared by the next start
//   o_m_axi_ar*/r*    AXI4-Lite read address / read data channels
//   o_pair_valid      o_pair_a/o_pair_b/o_pair_last are valid
//   i_pair_ready      downstream accepts the pair
//   o_pair_a/_b       A[i] / B[i]
//   o_pair_last       set on pair i = length-1
// ---------------------------------------------------------------------------
module dot_product_operand_fetch #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LEN_W        = 16,
  parameter int STRIDE_BYTES = 8
) (
  input  logic              i_m_axi_aclk,
  input  logic              i_m_axi_areset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_a,
  input  logic [ADDR_W-1:0] i_base_b,
  input  logic [LEN_W-1:0]  i_length,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_m_axi_araddr,
  output logic              o_m_axi_arvalid,
  input  logic              i_m_axi_arready,
  input  logic [DATA_W-1:0] i_m_axi_rdata,
  input  logic [1:0]        i_m_axi_rresp,
  input  logic              i_m_axi_rvalid,
  output logic              o_m_axi_rready,
  output logic              o_pair_valid,
  input  logic              i_pair_ready,
  output logic [DATA_W-1:0] o_pair_a,
  output logic [DATA_W-1:0] o_pair_b,
  output logic              o_pair_last
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR_A = 3'd1,
    S_R_A  = 3'd2,
    S_AR_B = 3'd3,
    S_R_B  = 3'd4,
    S_PUSH = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(STRIDE_BYTES);

  // Job context
  state_t              r_state;
  logic [ADDR_W-1:0]   r_base_a;
  logic [ADDR_W-1:0]   r_base_b;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_idx;
  // Byte offset of element r_idx, kept alongside the index so no multiplier is needed
  logic [ADDR_W-1:0]   r_off;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;

  // Registered outputs
  logic [ADDR_W-1:0]   r_araddr;
  logic                r_arvalid;
  logic                r_rready;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic                r_pair_valid;
  logic [DATA_W-1:0]   r_pair_a;
  logic [DATA_W-1:0]   r_pair_b;
  logic                r_pair_last;

  logic [ADDR_W-1:0]   w_off_next;
  logic                w_pair_load;
  logic                w_last;
  logic                w_rresp_ok;

  assign w_off_next  = r_off + STRIDE;
  // The output register frees up either when empty or when drained this cycle
  assign w_pair_load = (r_state == S_PUSH) && (!r_pair_valid || i_pair_ready);
  assign w_last      = (r_idx == (r_len - LEN_W'(1)));
  assign w_rresp_ok  = (i_m_axi_rresp == 2'b00);

  // Job sequencer: per element issue AR(A), take R(A), issue AR(B), take R(B), push the pair.
  always_ff @(posedge i_m_axi_aclk or posedge i_m_axi_areset) begin
    if (i_m_axi_areset) begin
      r_state   <= S_IDLE;
      r_base_a  <= '0;
      r_base_b  <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_off     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_araddr  <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      // done is a single-cycle pulse; only the transition into S_DONE raises it
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_base_a <= i_base_a;
            r_base_b <= i_base_b;
            r_len    <= i_length;
            r_idx    <= '0;
            r_off    <= '0;
            r_err    <= 1'b0;
            r_busy   <= 1'b1;
            if (i_length == '0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_araddr  <= i_base_a;
              r_arvalid <= 1'b1;
              r_state   <= S_AR_A;
            end
          end
        end

        S_AR_A: begin
          // Address stays put until the slave takes it
          if (i_m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R_A;
          end
        end

        S_R_A: begin
          if (i_m_axi_rvalid) begin
            r_rready <= 1'b0;
            if (w_rresp_ok) begin
              r_a       <= i_m_axi_rdata;
              r_araddr  <= r_base_b + r_off;
              r_arvalid <= 1'b1;
              r_state   <= S_AR_B;
            end else begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end

        S_AR_B: begin
          if (i_m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R_B;
          end
        end

        S_R_B: begin
          if (i_m_axi_rvalid) begin
            r_rready <= 1'b0;
            if (w_rresp_ok) begin
              r_b     <= i_m_axi_rdata;
              r_state <= S_PUSH;
            end else begin
              // Abort: A[i] is discarded, nothing partial reaches the output register
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end

        S_PUSH: begin
          if (w_pair_load) begin
            r_idx <= r_idx + LEN_W'(1);
            r_off <= w_off_next;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_araddr  <= r_base_a + w_off_next;
              r_arvalid <= 1'b1;
              r_state   <= S_AR_A;
            end
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  // Output pair register: loaded from the sequencer, drained by the consumer independently of the FSM.
  always_ff @(posedge i_m_axi_aclk or posedge i_m_axi_areset) begin
    if (i_m_axi_areset) begin
      r_pair_valid <= 1'b0;
      r_pair_a     <= '0;
      r_pair_b     <= '0;
      r_pair_last  <= 1'b0;
    end else if (w_pair_load) begin
      r_pair_valid <= 1'b1;
      r_pair_a     <= r_a;
      r_pair_b     <= r_b;
      r_pair_last  <= w_last;
    end else if (i_pair_ready) begin
      r_pair_valid <= 1'b0;
    end else begin
      r_pair_valid <= r_pair_valid;
    end
  end

  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_err           = r_err;
  assign o_m_axi_araddr  = r_araddr;
  assign o_m_axi_arvalid = r_arvalid;
  assign o_m_axi_rready  = r_rready;
  assign o_pair_valid    = r_pair_valid;
  assign o_pair_a        = r_pair_a;
  assign o_pair_b        = r_pair_b;
  assign o_pair_last     = r_pair_last;

  dot_product_operand_fetch_chk #(
    .ADDR_W (ADDR_W)
  ) u_chk (
    .i_clk     (i_m_axi_aclk),
    .i_rst     (i_m_axi_areset),
    .i_araddr  (r_araddr),
    .i_arvalid (r_arvalid),
    .i_arready (i_m_axi_arready),
    .i_rready  (r_rready),
    .i_busy    (r_busy),
    .i_done    (r_done)
  );

endmodule

// ---------------------------------------------------------------------------
// dot_product_operand_fetch_chk
//
// Protocol properties of the read master: a pending read address is held
// stable, address and data phases never overlap (one read outstanding), and
// done only pulses inside a job.
// ---------------------------------------------------------------------------
module dot_product_operand_fetch_chk #(
  parameter int ADDR_W = 32
) (
  input logic              i_clk,
  input logic              i_rst,
  input logic [ADDR_W-1:0] i_araddr,
  input logic              i_arvalid,
  input logic              i_arready,
  input logic              i_rready,
  input logic              i_busy,
  input logic              i_done
);

  a_ar_hold : assert property (@(posedge i_clk) disable iff (i_rst)
    (i_arvalid && !i_arready) |=> (i_arvalid && $stable(i_araddr)));

  a_one_outstanding : assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_arvalid && i_rready));

  a_done_in_job : assert property (@(posedge i_clk) disable iff (i_rst)
    i_done |-> i_busy);

endmodule
